// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 VGA raster counters with registered sync/blank decode and frame tick
module vga_timing #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    output logic       VGA_CLK,
    output logic [9:0] VGA_X,
    output logic [9:0] VGA_Y,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       frame_end
);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC - 1);
    localparam logic [9:0] H_BACK_END = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0] H_END      = 10'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC - 1);
    localparam logic [9:0] V_BACK_END = 10'(V_SYNC + V_BACK - 1);
    localparam logic [9:0] V_ACT_END  = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [9:0] V_END      = 10'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);

    typedef enum logic [1:0] {H_SYNC_ST, H_BACK_ST, H_ACT_ST, H_FRONT_ST} h_state_t;
    typedef enum logic [1:0] {V_SYNC_ST, V_BACK_ST, V_ACT_ST, V_FRONT_ST} v_state_t;

    h_state_t   h_state, h_next;
    v_state_t   v_state, v_next;
    logic       ph, line_wrap;
    logic [9:0] x_next, y_next;

    assign VGA_SYNC_N = 1'b0;
    assign VGA_CLK    = ph;
    assign line_wrap  = ph && h_state == H_FRONT_ST && VGA_X == H_END;

    // Horizontal region sequencing; x advances on each pixel step (ph high)
    always_comb begin
        h_next = h_state;
        x_next = VGA_X;
        if (ph) begin
            x_next = VGA_X + 10'd1;
            case (h_state)
                H_SYNC_ST:  if (VGA_X == H_SYNC_END) h_next = H_BACK_ST;
                H_BACK_ST:  if (VGA_X == H_BACK_END) h_next = H_ACT_ST;
                H_ACT_ST:   if (VGA_X == H_ACT_END)  h_next = H_FRONT_ST;
                H_FRONT_ST: if (VGA_X == H_END) begin
                    h_next = H_SYNC_ST;
                    x_next = '0;
                end
            endcase
        end
    end

    // Vertical region sequencing; y advances only when the line wraps
    always_comb begin
        v_next = v_state;
        y_next = VGA_Y;
        if (line_wrap) begin
            y_next = VGA_Y + 10'd1;
            case (v_state)
                V_SYNC_ST:  if (VGA_Y == V_SYNC_END) v_next = V_BACK_ST;
                V_BACK_ST:  if (VGA_Y == V_BACK_END) v_next = V_ACT_ST;
                V_ACT_ST:   if (VGA_Y == V_ACT_END)  v_next = V_FRONT_ST;
                V_FRONT_ST: if (VGA_Y == V_END) begin
                    v_next = V_SYNC_ST;
                    y_next = '0;
                end
            endcase
        end
    end

    // Counters, states and decodes share one edge so outputs stay aligned with X/Y
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ph          <= 1'b0;
            h_state     <= H_SYNC_ST;
            v_state     <= V_SYNC_ST;
            VGA_X       <= '0;
            VGA_Y       <= '0;
            VGA_HS      <= 1'b0;
            VGA_VS      <= 1'b0;
            VGA_BLANK_N <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            ph          <= ~ph;
            h_state     <= h_next;
            v_state     <= v_next;
            VGA_X       <= x_next;
            VGA_Y       <= y_next;
            VGA_HS      <= h_next != H_SYNC_ST;
            VGA_VS      <= v_next != V_SYNC_ST;
            VGA_BLANK_N <= h_next == H_ACT_ST && v_next == V_ACT_ST;
            frame_end   <= line_wrap && v_state == V_ACT_ST && VGA_Y == V_ACT_END;
        end
    end
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing, full-size and shrunken-raster instances
module tb_vga_timing;
    logic       clk, rst;
    logic [9:0] d_x, d_y, s_x, s_y;
    logic       d_ck, d_hs, d_vs, d_bl, d_sn, d_fe;
    logic       s_ck, s_hs, s_vs, s_bl, s_sn, s_fe;

    typedef struct {
        int         cyc;
        bit         inst;
        logic [9:0] x, y;
        logic       hs, vs, bl, fe, ck;
        int         fec;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         n_tests = 0, n_fail = 0;
    int         ecyc = 0, fec0 = 0, fec1 = 0;
    logic [25:0] got, want;

    vga_timing dut_full (
        .CLOCK_50(clk), .reset(rst), .VGA_CLK(d_ck), .VGA_X(d_x), .VGA_Y(d_y),
        .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_N(d_bl), .VGA_SYNC_N(d_sn), .frame_end(d_fe)
    );

    // Small raster: x 0..16 (sync 0..3, back 4..6, act 7..14, front 15..16),
    // y 0..8 (sync 0..1, back 2..3, act 4..6, front 7..8); frame = 306 cycles
    vga_timing #(
        .H_SYNC(4), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_ACTIVE(3), .V_FRONT(2)
    ) dut_small (
        .CLOCK_50(clk), .reset(rst), .VGA_CLK(s_ck), .VGA_X(s_x), .VGA_Y(s_y),
        .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bl), .VGA_SYNC_N(s_sn), .frame_end(s_fe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected snapshot at cycle c (CLOCK_50 edges since reset release) for instance i
    task automatic ex(input int c, input int i, input int x, input int y, input int hs,
                      input int vs, input int bl, input int fe, input int fec);
        exp_t t;
        t.cyc = c; t.inst = i[0]; t.x = 10'(x); t.y = 10'(y);
        t.hs = hs[0]; t.vs = vs[0]; t.bl = bl[0]; t.fe = fe[0]; t.ck = c[0]; t.fec = fec;
        q.push_back(t);
    endtask

    // Monitor: counts edges since release, tallies frame_end pulses, pops due snapshots
    initial forever begin
        @(posedge clk);
        if (!rst) ecyc++;
        @(negedge clk);
        if (rst) begin
            ecyc = 0; fec0 = 0; fec1 = 0;
        end
        fec0 += int'(d_fe);
        fec1 += int'(s_fe);
        while (q.size() > 0 && q[0].cyc <= ecyc) begin
            e = q.pop_front();
            want = {e.x, e.y, e.hs, e.vs, e.bl, e.fe, e.ck, 1'b0};
            got  = e.inst ? {s_x, s_y, s_hs, s_vs, s_bl, s_fe, s_ck, s_sn}
                          : {d_x, d_y, d_hs, d_vs, d_bl, d_fe, d_ck, d_sn};
            n_tests++;
            if (e.cyc != ecyc || got !== want || (e.inst ? fec1 : fec0) != e.fec) begin
                n_fail++;
                $display("FAIL snap_i%0d_c%0d: got x=%0d y=%0d hs,vs,bl,fe,clk,sync_n=%b fec=%0d at c%0d; expected x=%0d y=%0d %b fec=%0d",
                         e.inst, e.cyc, got[25:16], got[15:6], got[5:0], e.inst ? fec1 : fec0, ecyc,
                         want[25:16], want[15:6], want[5:0], e.fec);
            end
        end
    end

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d snapshots still pending, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        //  cyc  i   x    y  hs vs bl fe fec
        ex(0,    0,  0,   0, 0, 0, 0, 0, 0);
        ex(0,    1,  0,   0, 0, 0, 0, 0, 0);
        ex(1,    0,  0,   0, 0, 0, 0, 0, 0);
        ex(1,    1,  0,   0, 0, 0, 0, 0, 0);
        ex(2,    0,  1,   0, 0, 0, 0, 0, 0);
        ex(3,    0,  1,   0, 0, 0, 0, 0, 0);
        ex(4,    0,  2,   0, 0, 0, 0, 0, 0);
        ex(7,    1,  3,   0, 0, 0, 0, 0, 0);
        ex(8,    1,  4,   0, 1, 0, 0, 0, 0);
        ex(116,  1,  7,   3, 1, 1, 0, 0, 0);
        ex(149,  1,  6,   4, 1, 1, 0, 0, 0);
        ex(150,  1,  7,   4, 1, 1, 1, 0, 0);
        ex(191,  0,  95,  0, 0, 0, 0, 0, 0);
        ex(192,  0,  96,  0, 1, 0, 0, 0, 0);
        ex(232,  1,  14,  6, 1, 1, 1, 0, 0);
        ex(234,  1,  15,  6, 1, 1, 0, 0, 0);
        ex(237,  1,  16,  6, 1, 1, 0, 0, 0);
        ex(238,  1,  0,   7, 0, 1, 0, 1, 1);
        ex(239,  1,  0,   7, 0, 1, 0, 0, 1);
        ex(252,  1,  7,   7, 1, 1, 0, 0, 1);
        ex(304,  1,  16,  8, 1, 1, 0, 0, 1);
        ex(306,  1,  0,   0, 0, 0, 0, 0, 1);
        ex(544,  1,  0,   7, 0, 1, 0, 1, 2);
        ex(1599, 0,  799, 0, 1, 0, 0, 0, 0);
        ex(1600, 0,  0,   1, 0, 0, 0, 0, 0);
        ex(3199, 0,  799, 1, 1, 0, 0, 0, 0);
        ex(3200, 0,  0,   2, 0, 1, 0, 0, 0);
        ex(16800, 0, 400, 10, 1, 1, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        drain(20000);
        #1;
        ex(0,    0,  0,   0, 0, 0, 0, 0, 0);
        ex(0,    1,  0,   0, 0, 0, 0, 0, 0);
        ex(1,    0,  0,   0, 0, 0, 0, 0, 0);
        ex(1,    1,  0,   0, 0, 0, 0, 0, 0);
        ex(2,    0,  1,   0, 0, 0, 0, 0, 0);
        ex(7,    1,  3,   0, 0, 0, 0, 0, 0);
        ex(8,    1,  4,   0, 1, 0, 0, 0, 0);
        ex(237,  1,  16,  6, 1, 1, 0, 0, 0);
        ex(238,  1,  0,   7, 0, 1, 0, 1, 1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        drain(1000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
